// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator on the core data-memory interface.
// Define MEM_TIMEOUT_EN to abort an access with an error after TIMEOUT_CYCLES unanswered cycles.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_option,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        memory_read,
  output logic        memory_write,
  output logic [2:0]  option,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic        memory_response,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  state_t r_state;
  logic   r_write;
  logic   w_misaligned;
  logic   w_illegal;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wait_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    case (req_option[1:0])
      2'b01:   w_misaligned = req_address[0];
      2'b10:   w_misaligned = |req_address[1:0];
      default: w_misaligned = 1'b0;
    endcase
    // Size 11 and an unsigned-flagged store are never legal.
    w_illegal = w_misaligned | (&req_option[1:0]) | (req_option[2] & req_write);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_error    <= 1'b0;
      memory_read  <= 1'b0;
      memory_write <= 1'b0;
      option       <= 3'd0;
      address      <= 32'd0;
      write_data   <= 32'd0;
`ifdef MEM_TIMEOUT_EN
      r_wait_cnt   <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            r_write    <= req_write;
            option     <= req_option;
            address    <= req_address;
            write_data <= req_wdata;
            if (w_illegal) begin
              r_state   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              r_state      <= ST_ACCESS;
              memory_read  <= ~req_write;
              memory_write <= req_write;
`ifdef MEM_TIMEOUT_EN
              r_wait_cnt   <= 8'd0;
`endif
            end
          end
        end
        ST_ACCESS: begin
          if (memory_response) begin
            r_state      <= ST_RESP;
            memory_read  <= 1'b0;
            memory_write <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b0;
            rsp_rdata    <= r_write ? 32'd0 : read_data;
          end
`ifdef MEM_TIMEOUT_EN
          // A response in the limit cycle takes priority over the timeout.
          else if (r_wait_cnt == LP_LIMIT) begin
            r_state      <= ST_RESP;
            memory_read  <= 1'b0;
            memory_write <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b1;
            rsp_rdata    <= 32'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          rsp_rdata <= 32'd0;
        end
        default: begin
          r_state      <= ST_IDLE;
          req_ready    <= 1'b1;
          rsp_valid    <= 1'b0;
          memory_read  <= 1'b0;
          memory_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a delay-programmable memory responder.
// Timeout vectors run only when MEM_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4).
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_option;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        memory_read;
  logic        memory_write;
  logic [2:0]  option;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        memory_response;
  logic [31:0] read_data;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_delay;
  int r_hold;
  logic [31:0] mem [0:63];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_option(req_option), .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .memory_read(memory_read), .memory_write(memory_write),
    .option(option), .address(address), .write_data(write_data),
    .memory_response(memory_response), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: extends loads itself, acknowledges after resp_delay strobe cycles.
  function automatic logic [31:0] mem_rd(input logic [31:0] w, input logic [2:0] o, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (o[1:0])
      2'b00:   return o[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return o[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign memory_response = (memory_read | memory_write) && (r_hold >= resp_delay);
  assign read_data = mem_rd(mem[address[7:2]], option, address[1:0]);

  always @(posedge clk or negedge reset) begin
    if (!reset) r_hold <= 0;
    else if ((memory_read | memory_write) && !memory_response) r_hold <= r_hold + 1;
    else r_hold <= 0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[5] <= 32'h0000_0080;
    end else if (memory_write && memory_response) begin
      case (option[1:0])
        2'b00: mem[address[7:2]][8*address[1:0] +: 8] <= write_data[7:0];
        2'b01: if (address[1]) mem[address[7:2]][31:16] <= write_data[15:0];
               else            mem[address[7:2]][15:0]  <= write_data[15:0];
        default: mem[address[7:2]] <= write_data;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request through the LSU; hold keeps req_valid high (new address) during the wait.
  task automatic xact(input string tag, input bit hold, input logic w, input logic [2:0] opt,
                      input logic [31:0] a, input logic [31:0] d, input int e_lat, input int e_rd,
                      input int e_wr, input logic e_err, input logic [31:0] e_rdata);
    int lat, rd_cyc, wr_cyc, addr_bad, busy_bad, n;
    logic [31:0] rdata;
    logic err;
    lat = 0; rd_cyc = 0; wr_cyc = 0; addr_bad = 0; busy_bad = 0; n = 0;
    rdata = 32'hxxxx_xxxx; err = 1'bx;
    while (!req_ready && n < 32) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_write = w; req_option = opt; req_address = a; req_wdata = d;
    @(posedge clk); #1;
    if (hold) req_address = 32'h0000_0040;
    else req_valid = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      rd_cyc += int'(memory_read);
      wr_cyc += int'(memory_write);
      if (address !== a) addr_bad++;
      if (req_ready) busy_bad++;
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_error;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    $display("[TB] %s: w=%0b opt=%03b addr=%08h -> rdata=%08h err=%0b lat=%0d rd=%0d wr=%0d",
             tag, w, opt, a, rdata, err, lat, rd_cyc, wr_cyc);
    check({tag, "_lat"},   32'(lat),    32'(e_lat));
    check({tag, "_rd"},    32'(rd_cyc), 32'(e_rd));
    check({tag, "_wr"},    32'(wr_cyc), 32'(e_wr));
    check({tag, "_err"},   32'(err),    32'(e_err));
    check({tag, "_rdata"}, rdata,       e_rdata);
    check({tag, "_addr"},  32'(addr_bad), 32'd0);
    check({tag, "_busy"},  32'(busy_bad), 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_option = 3'd0;
    req_address = 32'd0; req_wdata = 32'd0; resp_delay = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_flags", {25'd0, rsp_valid, rsp_error, memory_read, memory_write, option}, 32'd0);
    check("rst_addr",  address, 32'd0);
    check("rst_wdata", write_data, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Basic store/load, sign/zero extension, legal half at the upper lane.
    xact("st_word",  0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 2, 0, 1, 1'b0, 32'h0);
    xact("ld_word",  0, 1'b0, 3'b010, 32'h10, 32'h0,         2, 1, 0, 1'b0, 32'hDEAD_BEEF);
    xact("ld_bs",    0, 1'b0, 3'b000, 32'h14, 32'h0,         2, 1, 0, 1'b0, 32'hFFFF_FF80);
    xact("ld_bu",    0, 1'b0, 3'b100, 32'h14, 32'h0,         2, 1, 0, 1'b0, 32'h0000_0080);
    xact("ld_hs_hi", 0, 1'b0, 3'b001, 32'h12, 32'h0,         2, 1, 0, 1'b0, 32'hFFFF_DEAD);
    xact("ld_b3",    0, 1'b0, 3'b000, 32'h13, 32'h0,         2, 1, 0, 1'b0, 32'hFFFF_FFDE);
    xact("st_byte",  0, 1'b1, 3'b000, 32'h21, 32'h0000_00AB, 2, 0, 1, 1'b0, 32'h0);
    xact("ld_w20",   0, 1'b0, 3'b010, 32'h20, 32'h0,         2, 1, 0, 1'b0, 32'h0000_AB00);

    // Misaligned / illegal: no strobes, error response one cycle after acceptance.
    xact("mis_half", 0, 1'b0, 3'b001, 32'h11, 32'h0,  1, 0, 0, 1'b1, 32'h0);
    xact("mis_word", 0, 1'b0, 3'b010, 32'h12, 32'h0,  1, 0, 0, 1'b1, 32'h0);
    xact("ill_sz3",  0, 1'b0, 3'b011, 32'h10, 32'h0,  1, 0, 0, 1'b1, 32'h0);
    xact("ill_sz3s", 0, 1'b1, 3'b011, 32'h10, 32'h55, 1, 0, 0, 1'b1, 32'h0);
    xact("ill_ust",  0, 1'b1, 3'b110, 32'h10, 32'h55, 1, 0, 0, 1'b1, 32'h0);
    xact("chk_mem",  0, 1'b0, 3'b010, 32'h10, 32'h0,  2, 1, 0, 1'b0, 32'hDEAD_BEEF);

    // Delayed responder with a competing req_valid held during the wait.
    resp_delay = 5;
    xact("slow_ld",  1, 1'b0, 3'b010, 32'h10, 32'h0, 7, 6, 0, 1'b0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("slow_noextra", {30'd0, memory_read, rsp_valid}, 32'd0);

`ifndef MEM_TIMEOUT_EN
    resp_delay = 20;
    xact("long_ld",  0, 1'b0, 3'b010, 32'h14, 32'h0, 22, 21, 0, 1'b0, 32'h0000_0080);
`endif

    // Reset while a store is waiting: outputs clear immediately, no response afterwards.
    resp_delay = 10;
    req_valid = 1'b1; req_write = 1'b1; req_option = 3'b010;
    req_address = 32'h18; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_wr", 32'(memory_write), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_flags", {25'd0, rsp_valid, rsp_error, memory_read, memory_write, option}, 32'd0);
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_addr",  address, 32'd0);
    check("arst_wdata", write_data, 32'd0);
    @(negedge clk) reset = 1'b1;
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      extra += int'(rsp_valid) + int'(memory_write);
    end
    $display("[TB] reset_abort: stray rsp/strobe cycles=%0d", extra);
    check("arst_norsp", 32'(extra), 32'd0);

`ifdef MEM_TIMEOUT_EN
    resp_delay = 1000;
    xact("tmo_err",  0, 1'b0, 3'b010, 32'h14, 32'h0, 5, 4, 0, 1'b1, 32'h0);
    resp_delay = 3;
    xact("tmo_edge", 0, 1'b0, 3'b010, 32'h14, 32'h0, 5, 4, 0, 1'b0, 32'h0000_0080);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
